sha256_msg_schedule: RTL and testbench



---
 rtl/sha256_pkg.sv | 42 ++++
 rtl/sha256_sched_step.sv | 15 +
 rtl/sha256_msg_schedule.sv | 116 +++++++++++
 tb/tb_sha256_msg_schedule.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// Shared SHA-256 types, sizes, small-sigma helpers and round constants.
package sha256_pkg;

    typedef logic [31:0] word_t;

    localparam int unsigned WORD_W     = 32;
    localparam int unsigned BLOCK_W    = 512;
    localparam int unsigned STATE_W    = 256;
    localparam int unsigned NUM_ROUNDS = 64;
    localparam int unsigned SCHED_INIT = 16;

    // Round constants, kept here so the compression core can share them.
    localparam word_t K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    // sigma0: ROTR7 ^ ROTR18 ^ SHR3
    function automatic word_t ssig0(input word_t x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    // sigma1: ROTR17 ^ ROTR19 ^ SHR10
    function automatic word_t ssig1(input word_t x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

endpackage

// File: rtl/sha256_sched_step.sv
// One combinational message-schedule recurrence step.
module sha256_sched_step
    import sha256_pkg::*;
(
    input  logic [31:0] w_m2,
    input  logic [31:0] w_m7,
    input  logic [31:0] w_m15,
    input  logic [31:0] w_m16,
    output logic [31:0] w_new
);

    // W[j] = s1(W[j-2]) + W[j-7] + s0(W[j-15]) + W[j-16], mod 2^32
    assign w_new = ssig1(w_m2) + w_m7 + ssig0(w_m15) + w_m16;

endmodule

// File: rtl/sha256_msg_schedule.sv
// Accepts a padded block + midstate, expands the 64-word schedule, then
// strobes en for one cycle with W and midstate held stable.
module sha256_msg_schedule
    import sha256_pkg::*;
#(
    parameter int unsigned STEPS_PER_CYCLE = 1   // 1, 2 or 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 blk_valid,
    output logic                 blk_ready,
    input  logic [BLOCK_W-1:0]   blk_data,
    input  logic [STATE_W-1:0]   midstate_in,
    output logic [31:0]          W [0:NUM_ROUNDS-1],
    output logic [STATE_W-1:0]   midstate,
    output logic                 en,
    output logic                 busy
);

    localparam int unsigned T_W = 7;
    localparam int unsigned S   = STEPS_PER_CYCLE;

    typedef enum logic [1:0] {IDLE, EXPAND, STROBE} state_t;

    state_t           state;
    logic [T_W-1:0]   t;
    logic [T_W-1:0]   t_next;
    logic             t_legal;

    word_t m2  [S];
    word_t m7  [S];
    word_t m15 [S];
    word_t m16 [S];
    word_t nw  [S];

    // Handshake and status decoded from registered state only
    assign blk_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    // Step group must start inside 16..64-S on an S-aligned boundary
    assign t_next  = t + T_W'(S);
    assign t_legal = (t >= T_W'(SCHED_INIT)) &&
                     (t <= T_W'(NUM_ROUNDS - S)) &&
                     ((t & T_W'(S - 1)) == '0);

    // Chain of recurrence steps; later steps take W[j-2] from earlier ones
    for (genvar k = 0; k < S; k++) begin : g_step
        if (k < 2) begin : g_reg
            assign m2[k] = W[6'(t + T_W'(k) - T_W'(2))];
        end else begin : g_chain
            assign m2[k] = nw[k-2];
        end
        assign m7[k]  = W[6'(t + T_W'(k) - T_W'(7))];
        assign m15[k] = W[6'(t + T_W'(k) - T_W'(15))];
        assign m16[k] = W[6'(t + T_W'(k) - T_W'(16))];

        sha256_sched_step u_step (
            .w_m2  (m2[k]),
            .w_m7  (m7[k]),
            .w_m15 (m15[k]),
            .w_m16 (m16[k]),
            .w_new (nw[k])
        );
    end

    // Control FSM with schedule storage; reset aborts and clears everything
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            t        <= T_W'(SCHED_INIT);
            en       <= 1'b0;
            midstate <= '0;
            for (int i = 0; i < NUM_ROUNDS; i++) begin
                W[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    en <= 1'b0;
                    if (blk_valid) begin
                        for (int i = 0; i < SCHED_INIT; i++) begin
                            W[i] <= blk_data[BLOCK_W-1-WORD_W*i -: WORD_W];
                        end
                        midstate <= midstate_in;
                        t        <= T_W'(SCHED_INIT);
                        state    <= EXPAND;
                    end
                end
                EXPAND: begin
                    if (t_legal) begin
                        for (int k = 0; k < S; k++) begin
                            W[6'(t + T_W'(k))] <= nw[k];
                        end
                        t <= t_next;
                        if (t_next == T_W'(NUM_ROUNDS)) begin
                            state <= STROBE;
                            en    <= 1'b1;
                        end
                    end else begin
                        state <= IDLE;
                        en    <= 1'b0;
                    end
                end
                STROBE: begin
                    en    <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    en    <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Bench for sha256_msg_schedule: three instances (S=1,2,4), known-answer
// table, randomized blocks against a reference model, and corner sequences.
module tb_sha256_msg_schedule;
    import sha256_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic [511:0] blk_data;
    logic [255:0] midstate_in;
    logic v0, v1, v2;
    logic r0, r1, r2;
    logic e0, e1, e2;
    logic b0, b1, b2;
    logic [255:0] m0, m1, m2;
    logic [31:0] w0 [0:63];
    logic [31:0] w1 [0:63];
    logic [31:0] w2 [0:63];

    always #5 clk = ~clk;

    sha256_msg_schedule #(.STEPS_PER_CYCLE(1)) u_s1 (
        .clk(clk), .rst(rst), .blk_valid(v0), .blk_ready(r0), .blk_data(blk_data),
        .midstate_in(midstate_in), .W(w0), .midstate(m0), .en(e0), .busy(b0));
    sha256_msg_schedule #(.STEPS_PER_CYCLE(2)) u_s2 (
        .clk(clk), .rst(rst), .blk_valid(v1), .blk_ready(r1), .blk_data(blk_data),
        .midstate_in(midstate_in), .W(w1), .midstate(m1), .en(e1), .busy(b1));
    sha256_msg_schedule #(.STEPS_PER_CYCLE(4)) u_s4 (
        .clk(clk), .rst(rst), .blk_valid(v2), .blk_ready(r2), .blk_data(blk_data),
        .midstate_in(midstate_in), .W(w2), .midstate(m2), .en(e2), .busy(b2));

    int n_pass  = 0;
    int n_total = 0;

    word_t exp_w [0:63];
    word_t got_w [0:63];

    localparam logic [255:0] IV =
        256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;

    typedef struct {
        string        name;
        logic [511:0] blk;
        logic [255:0] mid;
        logic [31:0]  w16;
        logic [31:0]  w17;
        logic [255:0] hash;
    } vec_t;

    vec_t vecs [2];

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [255:0] act, input logic [255:0] expv);
        n_total++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, expv);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int steps(input int d);
        case (d)
            0: return 1;
            1: return 2;
            default: return 4;
        endcase
    endfunction

    function automatic logic get_ready(input int d);
        case (d) 0: return r0; 1: return r1; default: return r2; endcase
    endfunction
    function automatic logic get_en(input int d);
        case (d) 0: return e0; 1: return e1; default: return e2; endcase
    endfunction
    function automatic logic get_busy(input int d);
        case (d) 0: return b0; 1: return b1; default: return b2; endcase
    endfunction
    function automatic logic [255:0] get_mid(input int d);
        case (d) 0: return m0; 1: return m1; default: return m2; endcase
    endfunction
    function automatic logic [31:0] get_w(input int d, input int j);
        case (d) 0: return w0[j]; 1: return w1[j]; default: return w2[j]; endcase
    endfunction

    task automatic set_valid(input int d, input logic v);
        case (d) 0: v0 = v; 1: v1 = v; default: v2 = v; endcase
    endtask

    task automatic snap(input int d);
        for (int j = 0; j < 64; j++) got_w[j] = get_w(d, j);
    endtask

    function automatic logic [511:0] rand512();
        logic [511:0] b;
        for (int j = 0; j < 16; j++) b[511-32*j -: 32] = $urandom();
        return b;
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] b;
        for (int j = 0; j < 8; j++) b[255-32*j -: 32] = $urandom();
        return b;
    endfunction

    // ---------------- reference model ----------------
    function automatic word_t rotr(input word_t x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Full 64-word schedule from the block, straight from the defining rule
    task automatic model_sched(input logic [511:0] blk);
        for (int j = 0; j < 16; j++) exp_w[j] = blk[511-32*j -: 32];
        for (int j = 16; j < 64; j++) begin
            word_t a, b;
            a = rotr(exp_w[j-2], 17) ^ rotr(exp_w[j-2], 19) ^ (exp_w[j-2] >> 10);
            b = rotr(exp_w[j-15], 7) ^ rotr(exp_w[j-15], 18) ^ (exp_w[j-15] >> 3);
            exp_w[j] = a + exp_w[j-7] + b + exp_w[j-16];
        end
    endtask

    // Compression of got_w onto a midstate, for known-answer hash checks
    task automatic compress(input logic [255:0] mid, output logic [255:0] hout);
        word_t a, b, c, d, e, f, g, h, t1, t2;
        {a, b, c, d, e, f, g, h} = mid;
        for (int i = 0; i < 64; i++) begin
            t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K[i] + got_w[i];
            t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            h = g; g = f; f = e; e = d + t1;
            d = c; c = b; b = a; a = t1 + t2;
        end
        hout = {a + mid[255:224], b + mid[223:192], c + mid[191:160], d + mid[159:128],
                e + mid[127:96],  f + mid[95:64],   g + mid[63:32],   h + mid[31:0]};
    endtask

    // Compare got_w against exp_w; reports the first differing word
    task automatic check_sched(input string tag);
        int bad;
        bad = 63;
        for (int j = 63; j >= 0; j--) if (got_w[j] !== exp_w[j]) bad = j;
        check($sformatf("%s W[%0d]", tag, bad), 256'(got_w[bad]), 256'(exp_w[bad]));
    endtask

    // Send one block to instance d, wait for en, check latency, W and midstate
    task automatic run_block(input int d, input logic [511:0] blk, input logic [255:0] mid,
                             input string tag);
        int lat;
        bit seen;
        for (int j = 0; j < 64; j++) got_w[j] = '0;
        blk_data    = blk;
        midstate_in = mid;
        set_valid(d, 1'b1);
        tick();
        set_valid(d, 1'b0);
        check($sformatf("%s ready_drop", tag), 256'(get_ready(d)), 256'(0));
        lat  = 0;
        seen = 1'b0;
        for (int k = 1; k <= 100 && !seen; k++) begin
            tick();
            if (get_en(d)) begin
                seen = 1'b1;
                lat  = k;
            end
        end
        check($sformatf("%s en_latency", tag), 256'(lat), 256'(48 / steps(d)));
        if (seen) begin
            model_sched(blk);
            snap(d);
            check_sched(tag);
            check($sformatf("%s midstate", tag), get_mid(d), mid);
            tick();
            check($sformatf("%s en_one_cycle", tag), 256'(get_en(d)), 256'(0));
            check($sformatf("%s ready_back", tag), 256'(get_ready(d)), 256'(1));
        end
    endtask

    // ---------------- test ----------------
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [511:0] blocks [3];
        logic [255:0] mids [3];
        logic [255:0] h;

        vecs[0] = '{"abc", {32'h61626380, 448'h0, 32'h00000018}, IV,
                    32'h61626380, 32'h000F0000,
                    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad};
        vecs[1] = '{"empty", {32'h80000000, 480'h0}, IV,
                    32'h80000000, 32'h00000000,
                    256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855};

        rst = 1'b1;
        v0 = 1'b0; v1 = 1'b0; v2 = 1'b0;
        blk_data = '0;
        midstate_in = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset ready", 256'(r0), 256'(1));
        check("reset busy", 256'(b0), 256'(0));
        check("reset en", 256'({e0, e1, e2}), 256'(0));
        check("reset midstate", m0, 256'(0));
        check("reset W0", 256'(w0[0]), 256'(0));
        check("reset W63", 256'(w2[63]), 256'(0));
        rst = 1'b0;
        tick();
        check("idle ready", 256'({r0, r1, r2}), 256'(3'b111));

        // Known-answer table on every instance
        for (int i = 0; i < 2; i++) begin
            for (int d = 0; d < 3; d++) begin
                string tag;
                tag = $sformatf("%s S%0d", vecs[i].name, steps(d));
                run_block(d, vecs[i].blk, vecs[i].mid, tag);
                check($sformatf("%s W16", tag), 256'(got_w[16]), 256'(vecs[i].w16));
                check($sformatf("%s W17", tag), 256'(got_w[17]), 256'(vecs[i].w17));
                compress(vecs[i].mid, h);
                check($sformatf("%s hash", tag), h, vecs[i].hash);
            end
        end

        // Randomized blocks
        for (int r = 0; r < 4; r++) begin
            for (int d = 0; d < 3; d++) begin
                run_block(d, rand512(), rand256(), $sformatf("rand%0d S%0d", r, steps(d)));
            end
        end

        // Back-to-back: blk_valid held high with three blocks (S=1)
        begin
            int acc, ens, pend;
            int en_cyc [3];
            bit pre, done;
            for (int i = 0; i < 3; i++) begin
                blocks[i] = rand512();
                mids[i]   = rand256();
                en_cyc[i] = 0;
            end
            acc = 0; ens = 0; pend = -1; done = 1'b0;
            blk_data = blocks[0];
            midstate_in = mids[0];
            v0 = 1'b1;
            for (int cyc = 1; cyc <= 400 && !done; cyc++) begin
                pre = r0 && v0;
                tick();
                if (pre) begin
                    acc++;
                    pend = -1;
                    if (acc < 3) begin
                        blk_data = blocks[acc];
                        midstate_in = mids[acc];
                    end else begin
                        v0 = 1'b0;
                    end
                end else if (pend >= 0) begin
                    snap(0);
                    check_sched($sformatf("b2b hold%0d", pend));
                    check($sformatf("b2b hold%0d mid", pend), m0, mids[pend]);
                end
                if (e0) begin
                    if (ens < 3) begin
                        en_cyc[ens] = cyc;
                        model_sched(blocks[ens]);
                        snap(0);
                        check_sched($sformatf("b2b blk%0d", ens));
                        check($sformatf("b2b blk%0d mid", ens), m0, mids[ens]);
                        pend = ens;
                    end
                    ens++;
                end
                if (ens >= 3 && cyc >= en_cyc[2] + 4) done = 1'b1;
            end
            v0 = 1'b0;
            check("b2b accepts", 256'(acc), 256'(3));
            check("b2b en_count", 256'(ens), 256'(3));
            check("b2b spacing01", 256'(en_cyc[1] - en_cyc[0]), 256'(50));
            check("b2b spacing12", 256'(en_cyc[2] - en_cyc[1]), 256'(50));
        end

        // Asynchronous reset with t=40, then a clean block
        begin
            logic [31:0] orw;
            blk_data = rand512();
            midstate_in = rand256();
            v0 = 1'b1;
            tick();
            v0 = 1'b0;
            repeat (24) tick();
            rst = 1'b1;
            #1;
            orw = '0;
            for (int j = 0; j < 64; j++) orw = orw | w0[j];
            check("abort W", 256'(orw), 256'(0));
            check("abort midstate", m0, 256'(0));
            check("abort en", 256'(e0), 256'(0));
            #2;
            rst = 1'b0;
            tick();
            check("abort ready", 256'(r0), 256'(1));
            check("abort busy", 256'(b0), 256'(0));
            run_block(0, rand512(), rand256(), "after_abort");
        end

        // blk_valid pulsed during EXPAND is ignored
        begin
            logic [511:0] blk_a;
            logic [255:0] mid_a;
            int lat, n_en, n_busy;
            blk_a = rand512();
            mid_a = rand256();
            blk_data = blk_a;
            midstate_in = mid_a;
            v0 = 1'b1;
            tick();
            v0 = 1'b0;
            repeat (10) tick();
            blk_data = rand512();
            midstate_in = rand256();
            v0 = 1'b1;
            tick();
            v0 = 1'b0;
            lat = 0; n_en = 0; n_busy = 0;
            for (int k = 12; k <= 80; k++) begin
                tick();
                if (e0) begin
                    n_en++;
                    if (lat == 0) begin
                        lat = k;
                        model_sched(blk_a);
                        snap(0);
                        check_sched("pulse");
                        check("pulse midstate", m0, mid_a);
                    end
                end
                if (k > 50 && b0) n_busy++;
            end
            check("pulse en_latency", 256'(lat), 256'(48));
            check("pulse en_count", 256'(n_en), 256'(1));
            check("pulse no_reaccept", 256'(n_busy), 256'(0));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
